// File: rtl/product_accumulator.sv
// product_accumulator
// -------------------
// Consumer end of the multiplier output stream in the MAC datapath. Signed
// products arrive over a valid/ready handshake. Each run of vec_len products
// (one vector) is summed into a signed, wrapping accumulator. Every completed
// sum is then offered on a valid/ready result port, with a sticky signed-overflow
// flag.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active low
//   mul_in     in   [MUL_WIDTH-1:0] signed product (two's complement)
//   mul_valid  in   mul_in is valid
//   mul_ready  out  product is accepted this cycle (low while rst is low)
//   vec_len    in   [LEN_WIDTH-1:0] products per vector, sampled on the first
//                   product of each vector; 0 means 1
//   acc_out    out  [ACC_WIDTH-1:0] completed signed sum (registered)
//   acc_ovf    out  signed overflow occurred somewhere in the vector
//   acc_valid  out  acc_out / acc_ovf are valid
//   acc_ready  in   downstream takes the result
//   busy       out  a vector is in progress (after its first product)
module product_accumulator #(
  parameter int MUL_WIDTH = 32,
  parameter int ACC_WIDTH = 40,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MUL_WIDTH-1:0] mul_in,
  input  logic                 mul_valid,
  output logic                 mul_ready,
  input  logic [LEN_WIDTH-1:0] vec_len,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 acc_ovf,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int CNT_WIDTH = LEN_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state_reg, state_next;
  logic [ACC_WIDTH-1:0]  acc_reg, acc_next;
  logic                  ovf_reg, ovf_next;
  logic [CNT_WIDTH-1:0]  count_reg, count_next;
  logic [CNT_WIDTH-1:0]  len_reg, len_next;

  logic                  ready_int;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  sum;
  logic                  add_ovf;
  logic [CNT_WIDTH-1:0]  first_len;
  logic [CNT_WIDTH-1:0]  count_inc;

  // Sign-extend the product to the accumulator width.
  assign prod_ext = ACC_WIDTH'($signed(mul_in));
  assign sum      = acc_reg + prod_ext;

  // Two's-complement overflow: both operands have the same sign and the
  // wrapped sum has the other sign.
  assign add_ovf  = (acc_reg[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);

  // A zero length is handled as a one-product vector.
  assign first_len = (vec_len == '0) ? CNT_ONE : {1'b0, vec_len};
  assign count_inc = count_reg + CNT_ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      count_reg <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
      count_reg <= count_next;
      len_reg   <= len_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    ovf_next   = ovf_reg;
    count_next = count_reg;
    len_next   = len_reg;
    ready_int  = 1'b0;

    case (state_reg)
      IDLE: begin
        ready_int = 1'b1;
        if (mul_valid) begin
          acc_next   = prod_ext;
          ovf_next   = 1'b0;
          count_next = CNT_ONE;
          len_next   = first_len;
          state_next = (first_len == CNT_ONE) ? HOLD : ACCUM;
        end
      end

      ACCUM: begin
        ready_int = 1'b1;
        if (mul_valid) begin
          acc_next   = sum;
          ovf_next   = ovf_reg | add_ovf;
          count_next = count_inc;
          if (count_inc == len_reg) begin
            state_next = HOLD;
          end
        end
      end

      HOLD: begin
        // The result slot frees up exactly when downstream takes it, so a new
        // first product can be loaded in that same cycle without a bubble.
        ready_int = acc_ready;
        if (acc_ready) begin
          if (mul_valid) begin
            acc_next   = prod_ext;
            ovf_next   = 1'b0;
            count_next = CNT_ONE;
            len_next   = first_len;
            state_next = (first_len == CNT_ONE) ? HOLD : ACCUM;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Nothing is taken while reset is asserted.
  assign mul_ready = rst & ready_int;
  assign acc_out   = acc_reg;
  assign acc_ovf   = ovf_reg;
  assign acc_valid = (state_reg == HOLD);
  assign busy      = (state_reg == ACCUM);

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  logic        clk;
  logic        rst;
  logic [31:0] mul_in;
  logic        mul_valid;
  logic        mul_ready;
  logic [7:0]  vec_len;
  logic [39:0] acc_out;
  logic        acc_ovf;
  logic        acc_valid;
  logic        acc_ready;
  logic        busy;

  // Second instance with a narrow accumulator for the overflow scenario.
  logic [31:0] b_mul_in;
  logic        b_mul_valid;
  logic        b_mul_ready;
  logic [7:0]  b_vec_len;
  logic [33:0] b_acc_out;
  logic        b_acc_ovf;
  logic        b_acc_valid;
  logic        b_acc_ready;
  logic        b_busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint      cur_q[$];
  int          model_cnt = 0;
  int          model_len = 0;
  logic [63:0] exp_sum_q[$];
  bit          exp_ovf_q[$];
  bit          last_acc = 0;

  product_accumulator #(.MUL_WIDTH(32), .ACC_WIDTH(40), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .mul_in(mul_in), .mul_valid(mul_valid),
    .mul_ready(mul_ready), .vec_len(vec_len), .acc_out(acc_out),
    .acc_ovf(acc_ovf), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .busy(busy)
  );

  product_accumulator #(.MUL_WIDTH(32), .ACC_WIDTH(34), .LEN_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .mul_in(b_mul_in), .mul_valid(b_mul_valid),
    .mul_ready(b_mul_ready), .vec_len(b_vec_len), .acc_out(b_acc_out),
    .acc_ovf(b_acc_ovf), .acc_valid(b_acc_valid), .acc_ready(b_acc_ready),
    .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wrap an exact integer into a w-bit signed range.
  function automatic longint wrap(input longint e, input int w);
    longint m, r, maxv;
    m    = longint'(1) <<< w;
    maxv = (longint'(1) <<< (w - 1)) - 1;
    r    = e % m;
    if (r < 0) r += m;
    if (r > maxv) r -= m;
    return r;
  endfunction

  // Sum a vector with w-bit wrapping; overflow whenever an exact running sum
  // leaves the representable signed range.
  function automatic void ref_sum(input longint p[$], input int w,
                                  output longint s, output bit ovf);
    longint maxv, minv, e;
    maxv = (longint'(1) <<< (w - 1)) - 1;
    minv = -(longint'(1) <<< (w - 1));
    s = 0;
    ovf = 0;
    foreach (p[i]) begin
      e = s + p[i];
      if (e > maxv || e < minv) ovf = 1;
      s = wrap(e, w);
    end
  endfunction

  function automatic logic [63:0] mask(input longint s, input int w);
    return 64'(s) & ((64'd1 << w) - 64'd1);
  endfunction

  // One clock cycle. Inputs are already set (at a negedge). Compare outputs
  // against the model, advance the model, and return at the next negedge.
  task automatic tick();
    bit ev, take, acc_m;
    longint s;
    bit o;
    #1;
    if (!rst) begin
      check("mul_ready_in_reset", mul_ready, 0);
      last_acc = 0;
    end else begin
      ev = (exp_sum_q.size() != 0);
      check("acc_valid", acc_valid, ev);
      check("busy", busy, model_cnt != 0);
      check("mul_ready", mul_ready, (!ev) || acc_ready);
      if (ev) begin
        check("acc_out", acc_out, exp_sum_q[0]);
        check("acc_ovf", acc_ovf, exp_ovf_q[0]);
      end
      take  = ev && acc_ready;
      acc_m = mul_valid && (!ev || acc_ready);
      if (take) begin
        void'(exp_sum_q.pop_front());
        void'(exp_ovf_q.pop_front());
        $display("result taken sum=%0h", acc_out);
      end
      if (acc_m) begin
        if (model_cnt == 0) begin
          model_len = (vec_len == 0) ? 1 : int'(vec_len);
          cur_q.delete();
        end
        cur_q.push_back(longint'($signed(mul_in)));
        model_cnt++;
        $display("product accepted %0d (%0d of %0d)", $signed(mul_in), model_cnt, model_len);
        if (model_cnt == model_len) begin
          ref_sum(cur_q, 40, s, o);
          exp_sum_q.push_back(mask(s, 40));
          exp_ovf_q.push_back(o);
          model_cnt = 0;
        end
      end
      last_acc = acc_m;
    end
    @(posedge clk);
    if (!rst) begin
      cur_q.delete();
      exp_sum_q.delete();
      exp_ovf_q.delete();
      model_cnt = 0;
    end
    @(negedge clk);
  endtask

  // Offer one product and wait (bounded) until it is accepted.
  task automatic send(input logic [31:0] d);
    bit got;
    got = 0;
    mul_valid = 1'b1;
    mul_in    = d;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (last_acc) begin
        got = 1;
        break;
      end
    end
    if (!got) check("send_timeout", got, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, "_acc_out"}, acc_out, 0);
    check({tag, "_acc_ovf"}, acc_ovf, 0);
    check({tag, "_acc_valid"}, acc_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    longint bs;
    bit     bo;
    longint bq[$];

    rst = 1'b0; mul_in = '0; mul_valid = 1'b0; vec_len = 8'd1; acc_ready = 1'b1;
    b_mul_in = '0; b_mul_valid = 1'b0; b_vec_len = 8'd1; b_acc_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;

    // Vector of 4: 3, -5, 10, 2 back-to-back -> 10
    vec_len = 8'd4;
    send(32'd3);
    send(-32'sd5);
    send(32'd10);
    send(32'd2);
    mul_valid = 1'b0;
    acc_ready = 1'b0;
    #1;
    check("vec4_valid", acc_valid, 1);
    check("vec4_sum", acc_out, 40'd10);
    check("vec4_ovf", acc_ovf, 0);
    tick();
    acc_ready = 1'b1;
    tick();
    tick();

    // vec_len 0 behaves as length 1
    vec_len = 8'd0;
    send(-32'sd7);
    mul_valid = 1'b0;
    acc_ready = 1'b0;
    #1;
    check("len0_valid", acc_valid, 1);
    check("len0_sum", acc_out, 40'hFFFFFFFFF9);
    tick();
    acc_ready = 1'b1;
    tick();

    // Backpressure in HOLD with a product waiting, then take + load together
    vec_len = 8'd2;
    send(32'd100);
    send(-32'sd1);
    acc_ready = 1'b0;
    mul_valid = 1'b1;
    mul_in    = 32'd5;
    vec_len   = 8'd1;
    repeat (5) tick();
    acc_ready = 1'b1;
    tick();
    check("hold_load_accept", last_acc, 1);
    mul_valid = 1'b0;
    tick();
    tick();

    // Reset mid-vector discards the partial sum
    vec_len = 8'd3;
    send(32'd1);
    send(32'd2);
    mul_valid = 1'b0;
    rst = 1'b0;
    tick();
    check_reset_outputs("midreset");
    rst = 1'b1;
    vec_len = 8'd2;
    send(32'd4);
    send(32'd4);
    mul_valid = 1'b0;
    #1;
    check("after_reset_sum", acc_out, 40'd8);
    tick();
    tick();

    // Mid-vector vec_len change is ignored
    vec_len = 8'd3;
    send(32'd11);
    vec_len = 8'd7;
    send(32'd22);
    send(32'd33);
    mul_valid = 1'b0;
    #1;
    check("len_change_valid", acc_valid, 1);
    check("len_change_sum", acc_out, 40'd66);
    tick();
    tick();

    // Overflow on the 34-bit instance: 5 x 0x7FFFFFFF
    bq.delete();
    b_vec_len   = 8'd5;
    b_mul_valid = 1'b1;
    b_mul_in    = 32'h7FFFFFFF;
    for (int i = 0; i < 5; i++) begin
      bq.push_back(longint'(32'h7FFFFFFF));
      #1;
      check("b_mul_ready", b_mul_ready, 1);
      @(posedge clk);
      @(negedge clk);
    end
    b_mul_valid = 1'b0;
    ref_sum(bq, 34, bs, bo);
    #1;
    check("b_ovf_valid", b_acc_valid, 1);
    check("b_ovf_sum", b_acc_out, mask(bs, 34));
    check("b_ovf_flag", b_acc_ovf, bo);
    $display("narrow result sum=%0h ovf=%0d", b_acc_out, b_acc_ovf);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("b_taken", b_acc_valid, 0);
    b_vec_len   = 8'd2;
    b_mul_valid = 1'b1;
    b_mul_in    = 32'd1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    b_mul_valid = 1'b0;
    #1;
    check("b_next_valid", b_acc_valid, 1);
    check("b_next_sum", b_acc_out, 34'd2);
    check("b_next_ovf", b_acc_ovf, 0);
    $display("narrow result sum=%0h ovf=%0d", b_acc_out, b_acc_ovf);
    @(posedge clk);
    @(negedge clk);

    // Randomised traffic: held products, random gaps and lengths
    mul_valid = 1'b0;
    last_acc  = 0;
    for (int i = 0; i < 400; i++) begin
      if (!mul_valid || last_acc) begin
        mul_valid = ($urandom_range(0, 3) != 0);
        mul_in    = $urandom;
        if ($urandom_range(0, 2) == 0) mul_in = 32'h7FFFFFFF - 32'($urandom_range(0, 3));
      end
      acc_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) vec_len = 8'($urandom_range(0, 7));
      tick();
    end
    mul_valid = 1'b0;
    acc_ready = 1'b1;
    tick();
    tick();
    check("drain_valid", acc_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
